controle_multiciclo: RTL
========================

// Module: controle_multiciclo
// PURPOSE
// Multi-cycle sequencer for the RISC-V datapath. Fetches instructions over an imem req/ack handshake
// and decodes opcode[6:4], funct3 and funct7. Steps FETCH/DECODE/EXEC/MEM/WB and drives the datapath
// controls (regiwrite, memread, memwrite, alucontrol, alusrc, memtoreg) plus PC/IR enables.
// It replaces per-clock decoding with a state-sequenced control path.
// PARAMETERS
// WAIT_MAX  15  max cycles a req may wait for ack before fault; 0 = no timeout
// CNT_W     16  width of retired-instruction counter
// PORTS
// clk          in   1      clock, rising edge
// rst          in   1      asynchronous active-high reset
// start        in   1      leave IDLE and begin fetching (sampled in IDLE only)
// instr        in   32     instruction word from imem, valid with imem_ack
// imem_req     out  1      instruction fetch request
// imem_ack     in   1      fetch complete, instr valid this cycle
// dmem_req     out  1      data memory request
// dmem_ack     in   1      data access complete
// zero         in   1      ALU zero flag
// ir_write     out  1      load instruction register
// pc_write     out  1      update PC
// pc_src       out  1      0 = PC+4, 1 = branch target
// regiwrite    out  1      register file write enable
// memread      out  1      data read (lw)
// memwrite     out  1      data write (sw)
// alucontrol   out  4      ALU operation
// alusrc       out  1      0 = rs2, 1 = immediate
// memtoreg     out  1      0 = ALU result, 1 = memory data to rd
// state        out  3      IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 HALT=6
// err          out  2      sticky: 00 none, 01 handshake timeout, 10 illegal instruction
// retired      out  CNT_W  retired-instruction count, wraps to 0
// BEHAVIOUR
// - Reset: state=IDLE; err=0; retired=0; internal IR=0; all other outputs 0. Reset mid-operation drops
//   imem_req/dmem_req immediately (async) and abandons the instruction; nothing is retired.
// - Outputs are Moore: decoded from state and latched IR only, never from same-cycle inputs.
//   Exception: ir_write and the EXEC/MEM/WB pc_write/pc_src (may depend on ack/zero).
// - Opcode decode on opcode[6:4]: 000 lw, 001 addi, 010 sw, 011 R-type, 110 beq; all others illegal.
// - alucontrol: lw/sw/add 0010, addi 0011, sub 0110, xor 0100, srl 0101, and 0000, or 0001, beq 0110.
// - R-type decode: funct3 000 with funct7[6:5] = 00 is add, 01 is sub, 1x is illegal.
//   funct3 100/101/111/110 are xor/srl/and/or; funct3 001/010/011 are illegal.
// - IDLE: start=1 -> FETCH.
// - FETCH: imem_req=1 until imem_ack. In the ack cycle, ir_write=1 and IR<=instr; next state DECODE.
// - DECODE: one cycle. Illegal opcode -> HALT with err=10; otherwise -> EXEC.
// - EXEC: alucontrol/alusrc driven (alusrc=1 for lw/sw/addi/beq). Next state by opcode:
//   beq: pc_write=1, pc_src=zero, retire, -> FETCH. lw/sw -> MEM. addi/R-type -> WB.
// - MEM: dmem_req=1 and alucontrol/alusrc held. memread=1 (lw) or memwrite=1 (sw) for every req cycle.
//   On dmem_ack, sw does pc_write=1, pc_src=0, retire, -> FETCH; lw -> WB.
// - WB: regiwrite=1 for one cycle (memtoreg=1 for lw, else 0). Same cycle: pc_write=1, pc_src=0,
//   retire, -> FETCH.
// - Retire: retired<=retired+1, mod 2^CNT_W.
// - Timeout: wait counter clears on entry to FETCH/MEM and counts req cycles without ack. If ack is
//   still absent after WAIT_MAX req cycles, next state is HALT with err=01. Ack on cycle WAIT_MAX is
//   accepted, not a fault.
// - HALT: all strobes 0; state, err and retired hold until rst.
// - start outside IDLE is ignored. Ack while the matching req is low is ignored.
// - Latency with zero-wait acks: beq 3 cycles; add/addi/sw 4; lw 5.
// TESTING
// - rst, start=1, imem_ack tied 1, instr=add x3,x1,x2 (0x002081B3):
//   states 1,2,3,5; WB cycle has regiwrite=1, alucontrol=0010, pc_write=1; retired=1.
// - lw (0x0000A183) with dmem_ack delayed 3 cycles: memread=1 and dmem_req=1 for exactly 4 cycles.
//   WB has memtoreg=1, regiwrite=1; 5+3 cycles from FETCH to next FETCH.
// - beq (0x00208663) with zero=1 -> EXEC has pc_write=1, pc_src=1, regiwrite=0.
//   Repeat with zero=0 -> pc_src=0.
// - imem_ack held 0: WAIT_MAX=15 req cycles, then state=6, err=01, imem_req=0; start/acks ignored
//   until rst.
// - instr with opcode 0x7F (or R-type funct3=001): DECODE -> HALT, err=10, no regiwrite, retired
//   unchanged.
// - rst asserted mid-MEM on sw: dmem_req and memwrite drop the same cycle; state=0, retired unchanged.

Source files
------------

// File: rtl/controle_multiciclo.sv
`default_nettype none
// ============================================================================
// Module   : controle_multiciclo
// Purpose  : Multi-cycle control sequencer for a RISC-V datapath. It fetches
//            an instruction over an imem req/ack handshake, latches it into
//            an internal IR and steps FETCH/DECODE/EXEC/MEM/WB to drive the
//            datapath controls.
// Ports    : clk, rst (async, active high), start
//            instr, imem_req, imem_ack      - instruction fetch handshake
//            dmem_req, dmem_ack             - data memory handshake
//            zero                           - ALU zero flag (beq)
//            ir_write, pc_write, pc_src     - IR / PC update controls
//            regiwrite, memread, memwrite, alucontrol, alusrc, memtoreg
//            state (3b), err (2b sticky), retired (CNT_W)
// Revision : 1.0 - initial release
// ============================================================================
module controle_multiciclo #(
   parameter int WAIT_MAX = 15,   // req cycles allowed without ack; 0 = no timeout
   parameter int CNT_W    = 16    // retired-instruction counter width
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [31:0]      instr,
   output logic             imem_req,
   input  logic             imem_ack,
   output logic             dmem_req,
   input  logic             dmem_ack,
   input  logic             zero,
   output logic             ir_write,
   output logic             pc_write,
   output logic             pc_src,
   output logic             regiwrite,
   output logic             memread,
   output logic             memwrite,
   output logic [3:0]       alucontrol,
   output logic             alusrc,
   output logic             memtoreg,
   output logic [2:0]       state,
   output logic [1:0]       err,
   output logic [CNT_W-1:0] retired
);

   localparam int WAIT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
   // Value of the wait counter during the last permitted req cycle.
   localparam logic [WAIT_W-1:0] WAIT_LAST = (WAIT_MAX == 0) ? '0 : WAIT_W'(WAIT_MAX - 1);

   localparam logic [1:0] ERR_TIMEOUT = 2'b01;
   localparam logic [1:0] ERR_ILLEGAL = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   state_t            cur;
   logic [31:0]       ir;
   logic [WAIT_W-1:0] wait_cnt;
   logic [1:0]        err_r;
   logic [CNT_W-1:0]  retired_r;

   // ---------------- decode of the latched IR ----------------
   logic       is_lw, is_sw, is_addi, is_r, is_beq, illegal;
   logic [3:0] alu_op;

   always_comb begin
      is_lw   = 1'b0;
      is_sw   = 1'b0;
      is_addi = 1'b0;
      is_r    = 1'b0;
      is_beq  = 1'b0;
      illegal = 1'b0;
      alu_op  = 4'b0000;
      case (ir[6:4])
         3'b000: begin is_lw   = 1'b1; alu_op = 4'b0010; end
         3'b001: begin is_addi = 1'b1; alu_op = 4'b0011; end
         3'b010: begin is_sw   = 1'b1; alu_op = 4'b0010; end
         3'b110: begin is_beq  = 1'b1; alu_op = 4'b0110; end
         3'b011: begin
            is_r = 1'b1;
            case (ir[14:12])
               // funct7[6] set is not a valid add/sub encoding
               3'b000: begin
                  if (ir[31]) illegal = 1'b1;
                  else        alu_op  = ir[30] ? 4'b0110 : 4'b0010;
               end
               3'b100:  alu_op  = 4'b0100;
               3'b101:  alu_op  = 4'b0101;
               3'b111:  alu_op  = 4'b0000;
               3'b110:  alu_op  = 4'b0001;
               default: illegal = 1'b1;
            endcase
         end
         default: illegal = 1'b1;
      endcase
   end

   // IR bits the control path never looks at (register indices, immediates).
   logic unused_ir_bits;
   assign unused_ir_bits = ^{ir[29:15], ir[11:7], ir[3:0]};

   logic wait_hit;
   assign wait_hit = (WAIT_MAX != 0) && (wait_cnt == WAIT_LAST);

   // ---------------- sequencer ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur       <= S_IDLE;
         ir        <= '0;
         wait_cnt  <= '0;
         err_r     <= '0;
         retired_r <= '0;
      end else begin
         case (cur)
            S_IDLE: begin
               if (start) begin
                  cur      <= S_FETCH;
                  wait_cnt <= '0;
               end
            end
            S_FETCH: begin
               if (imem_ack) begin
                  ir  <= instr;
                  cur <= S_DECODE;
               end else if (wait_hit) begin
                  cur   <= S_HALT;
                  err_r <= ERR_TIMEOUT;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            S_DECODE: begin
               if (illegal) begin
                  cur   <= S_HALT;
                  err_r <= ERR_ILLEGAL;
               end else begin
                  cur <= S_EXEC;
               end
            end
            S_EXEC: begin
               wait_cnt <= '0;
               if (is_beq) begin
                  retired_r <= retired_r + CNT_W'(1);
                  cur       <= S_FETCH;
               end else if (is_lw || is_sw) begin
                  cur <= S_MEM;
               end else begin
                  cur <= S_WB;
               end
            end
            S_MEM: begin
               if (dmem_ack) begin
                  if (is_sw) begin
                     retired_r <= retired_r + CNT_W'(1);
                     wait_cnt  <= '0;
                     cur       <= S_FETCH;
                  end else begin
                     cur <= S_WB;
                  end
               end else if (wait_hit) begin
                  cur   <= S_HALT;
                  err_r <= ERR_TIMEOUT;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            S_WB: begin
               retired_r <= retired_r + CNT_W'(1);
               wait_cnt  <= '0;
               cur       <= S_FETCH;
            end
            S_HALT:  cur <= S_HALT;
            default: cur <= S_IDLE;
         endcase
      end
   end

   // ---------------- outputs (Moore except ack/zero-qualified strobes) ----------------
   logic alu_phase;
   assign alu_phase  = (cur == S_EXEC) || (cur == S_MEM) || (cur == S_WB);

   assign state      = cur;
   assign err        = err_r;
   assign retired    = retired_r;
   assign imem_req   = (cur == S_FETCH);
   assign ir_write   = (cur == S_FETCH) && imem_ack;
   assign dmem_req   = (cur == S_MEM);
   assign memread    = (cur == S_MEM) && is_lw;
   assign memwrite   = (cur == S_MEM) && is_sw;
   assign alucontrol = alu_phase ? alu_op : 4'b0000;
   assign alusrc     = alu_phase && (is_lw || is_sw || is_addi || is_beq);
   assign regiwrite  = (cur == S_WB);
   assign memtoreg   = (cur == S_WB) && is_lw;
   assign pc_write   = ((cur == S_EXEC) && is_beq)
                     || ((cur == S_MEM) && is_sw && dmem_ack)
                     || (cur == S_WB);
   assign pc_src     = (cur == S_EXEC) && is_beq && zero;

endmodule
`default_nettype wire
